// File: rtl/eth_mac_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : eth_mac_tx_arb
// Description : Frame-granular round-robin arbiter in front of the 1G MAC
//               8-bit transmit AXI-stream port. A grant runs from the first
//               beat to the tlast beat; frames are never interleaved.
//               Optional stall watchdog, enabled by ETH_TX_ARB_WATCHDOG_EN:
//               a source that stalls mid-frame gets its frame closed with an
//               errored tlast beat. The rest of that frame is then discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_mac_tx_arb #(
  parameter int S_COUNT          = 4,
  parameter int WATCHDOG_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [S_COUNT*8-1:0]       s_axis_tdata,
  input  logic [S_COUNT-1:0]         s_axis_tvalid,
  output logic [S_COUNT-1:0]         s_axis_tready,
  input  logic [S_COUNT-1:0]         s_axis_tlast,
  input  logic [S_COUNT-1:0]         s_axis_tuser,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic                       grant_valid,
  output logic [$clog2(S_COUNT)-1:0] grant_index,
  output logic                       watchdog_abort
);

  localparam int IDX_W = $clog2(S_COUNT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;
  localparam int         WD_W     = $clog2(WATCHDOG_TIMEOUT);
`endif

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic             req_found;
  logic [IDX_W-1:0] req_sel;

  // Fields of the currently granted requester, selected by the registered grant
  logic [7:0] sel_tdata;
  logic       sel_tvalid;
  logic       sel_tlast;
  logic       sel_tuser;
  logic       xfer_hs;

  assign sel_tdata  = s_axis_tdata[{grant_q, 3'b000} +: 8];
  assign sel_tvalid = s_axis_tvalid[grant_q];
  assign sel_tlast  = s_axis_tlast[grant_q];
  assign sel_tuser  = s_axis_tuser[grant_q];
  assign xfer_hs    = (state_q == ST_XFER) && sel_tvalid && m_axis_tready;
  assign grant_index = grant_q;

  // Index that is 'off' positions above 'base', wrapping at S_COUNT
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % S_COUNT;
    return s[IDX_W-1:0];
  endfunction

  // Round-robin search starting just above the last served requester
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    for (int i = 1; i <= S_COUNT; i++) begin
      if (!req_found && s_axis_tvalid[rr_index(last_q, i)]) begin
        req_found = 1'b1;
        req_sel   = rr_index(last_q, i);
      end
    end
  end

`ifdef ETH_TX_ARB_WATCHDOG_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_trip;

  assign wd_trip = (state_q == ST_XFER) && !sel_tvalid &&
                   (wd_q == WD_W'(WATCHDOG_TIMEOUT - 1));

  // Stall counter: counts cycles with no data from the granted source
  always_comb begin
    wd_d = wd_q;
    if (state_q != ST_XFER || xfer_hs) begin
      wd_d = '0;
    end else if (!sel_tvalid) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // Timeout has no effect without the watchdog; keep it referenced
  logic unused_wd_cfg;
  assign unused_wd_cfg = ^WATCHDOG_TIMEOUT;
`endif

  // State, grant and last-grant pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(S_COUNT - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic; a tlast handshake takes precedence over a watchdog trip
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          state_d = ST_XFER;
          grant_d = req_sel;
          last_d  = req_sel;
        end
      end
      ST_XFER: begin
        if (xfer_hs && sel_tlast) begin
          state_d = ST_IDLE;
        end
`ifdef ETH_TX_ARB_WATCHDOG_EN
        else if (wd_trip) begin
          state_d = ST_ABORT;
        end
`endif
      end
`ifdef ETH_TX_ARB_WATCHDOG_EN
      ST_ABORT: begin
        if (m_axis_tready) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (sel_tvalid && sel_tlast) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: pass-through mux in XFER, synthetic errored beat in ABORT,
  // sink-only in DROP, everything quiet otherwise
  always_comb begin
    s_axis_tready  = '0;
    m_axis_tdata   = 8'h00;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    grant_valid    = (state_q != ST_IDLE);
    watchdog_abort = 1'b0;
    case (state_q)
      ST_XFER: begin
        m_axis_tdata           = sel_tdata;
        m_axis_tvalid          = sel_tvalid;
        m_axis_tlast           = sel_tlast;
        m_axis_tuser           = sel_tuser;
        s_axis_tready[grant_q] = m_axis_tready;
      end
`ifdef ETH_TX_ARB_WATCHDOG_EN
      ST_ABORT: begin
        m_axis_tvalid  = 1'b1;
        m_axis_tlast   = 1'b1;
        m_axis_tuser   = 1'b1;
        watchdog_abort = m_axis_tready;
      end
      ST_DROP: begin
        s_axis_tready[grant_q] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/eth_mac_tx_arb.md
# eth_mac_tx_arb

Frame-granular round-robin arbiter that shares the 1G MAC transmit AXI-stream input (8-bit) among `S_COUNT` requesters. It sits in the `gtx_clk`/`tx_clk` domain directly in front of the MAC `tx_axis_*` port. It never interleaves frames: a grant lasts from the first beat to the `tlast` beat. An optional watchdog aborts frames whose source stalls mid-frame, so a hung requester cannot block the link.

## Interface
- `S_COUNT`, 4: number of requesters, 2..16.
- `WATCHDOG_TIMEOUT`, 1024: stall cycles before abort. Used only with `ETH_TX_ARB_WATCHDOG_EN`. Must be ≥2.
- `clk`  in  1  transmit clock (MAC `tx_clk`). This is the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  S_COUNT*8  requester data; requester i uses bits [8i+7:8i].
- `s_axis_tvalid`  in  S_COUNT  per-requester valid.
- `s_axis_tready`  out  S_COUNT  per-requester ready.
- `s_axis_tlast`  in  S_COUNT  per-requester end of frame.
- `s_axis_tuser`  in  S_COUNT  per-requester bad-frame flag.
- `m_axis_tdata`  out  8  to MAC `tx_axis_tdata`.
- `m_axis_tvalid`  out  1  to MAC.
- `m_axis_tready`  in  1  from MAC.
- `m_axis_tlast`  out  1  to MAC.
- `m_axis_tuser`  out  1  to MAC.
- `grant_valid`  out  1  a frame is currently granted.
- `grant_index`  out  $clog2(S_COUNT)  index of the granted (or last granted) requester.
- `watchdog_abort`  out  1  one-cycle pulse when an abort beat is accepted by the MAC.

## Operation
- **States:** IDLE, XFER, ABORT, DROP. The state, grant index and last-grant pointer `last_q` are all registered.
- **IDLE**
  - `grant_valid`=0. All `s_axis_tready`=0. `m_axis_tvalid`=0.
  - If any `s_axis_tvalid` is high, select the first asserted index searching upward from `last_q+1`, modulo `S_COUNT`.
  - Next cycle: `grant_index`=selected, `last_q`=selected, state=XFER.
- **XFER**
  - Combinational pass-through of granted requester g: `m_axis_tdata/tvalid/tlast/tuser` = `s_axis_*[g]`.
  - `s_axis_tready[g]` = `m_axis_tready`. All other `s_axis_tready`=0.
  - On the handshake of a beat with `tlast`=1, the next state is IDLE.
- **Fairness:** the requester just served has lowest priority in the next arbitration. A requester that holds `tvalid` is served within `S_COUNT` frames.
- **Stall watchdog** (macro only)
  - In XFER, counter `wd` increments on each cycle with `s_axis_tvalid[g]`=0. It clears on any granted handshake and on entry to XFER.
  - When `wd` reaches `WATCHDOG_TIMEOUT-1` while stalled, the next state is ABORT.
- **ABORT**
  - Drives `m_axis_tvalid`=1, `tdata`=0x00, `tlast`=1, `tuser`=1. `s_axis_tready[g]`=0.
  - When `m_axis_tready`=1: pulse `watchdog_abort` and go to DROP.
  - The MAC treats this beat as an errored frame end.
- **DROP**
  - `m_axis_tvalid`=0. `s_axis_tready[g]`=1, and beats of g are discarded.
  - On a discarded beat with `tlast`=1, go to IDLE.
  - DROP has no timeout.
- **Reset values:** state=IDLE, `last_q`=S_COUNT-1 (first grant goes to index 0), `grant_index`=0, `grant_valid`=0, `watchdog_abort`=0, `wd`=0. All `s_axis_tready`=0, `m_axis_tvalid`=0; `m_axis_tdata`=0, `tlast`=0, `tuser`=0.
- **Reset mid-frame:** the frame is truncated without a `tlast` beat. Downstream must also be reset; no recovery beat is generated.
- **Simultaneous events:** a `tlast` handshake in the same cycle as a watchdog threshold counts as normal completion (IDLE), since a handshake clears `wd`.
- A requester dropping `tvalid` in IDLE before it is granted loses arbitration with no side effect.

## Timing
- Arbitration latency: one cycle. `tvalid` seen in IDLE at cycle N gives the grant at N+1, and the first beat can transfer at N+1.
- There is one idle cycle between back-to-back frames: the IDLE cycle after `tlast`.
- Data path: zero latency in XFER. `m_axis_*` and `s_axis_tready` are combinational through a registered-select mux.
- A single-beat frame (`tlast` on the first beat) occupies XFER for one handshake cycle.
- Abort: with continuous `m_axis_tready`, the ABORT beat is presented `WATCHDOG_TIMEOUT` cycles after the last granted handshake (or after XFER entry).

## Configuration
- `ETH_TX_ARB_WATCHDOG_EN`
  - **Defined:** the `wd` counter, ABORT and DROP are built as described.
  - **Undefined:** XFER waits indefinitely on a stalled source. ABORT, DROP and `wd` are not synthesised, `watchdog_abort` is tied 0, and `WATCHDOG_TIMEOUT` is ignored.

## Test plan
- **Reset then simultaneous requests:** reset, then requesters 0 and 2 each send a 3-byte frame (0xA1,0xA2,0xA3 / 0xC1,0xC2,0xC3) with `m_axis_tready`=1 → output sequence A1 A2 A3, one idle cycle, C1 C2 C3; `grant_index` is 0 then 2.
- **Fairness:** all 4 requesters continuously valid with 2-byte frames → grant order 0,1,2,3,0 and no frame interleaving.
- **Backpressure:** `m_axis_tready` toggles 1,0,1,0 during a 5-byte frame from requester 1 → all 5 bytes are delivered in order; `s_axis_tready[1]` mirrors `m_axis_tready`; other readies stay 0.
- **Watchdog abort** (macro, `WATCHDOG_TIMEOUT`=16): requester 3 sends 2 bytes then stalls → after 16 stall cycles the MAC sees a beat 0x00 with `tlast`=1, `tuser`=1 and `watchdog_abort` pulses once; requester 3's later 4 bytes ending in `tlast` are consumed and do not appear on `m_axis`; then requester 0 is granted.
- **No macro, same stimulus:** no abort beat is generated; `grant_index` stays 3 and the remaining bytes pass through after the stall.
- **Reset mid-frame:** `rst` asserted on byte 2 of a frame → next cycle all outputs are at reset values, and the next grant goes to requester 0.
